// File: rtl/pdec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pdec_pkg
// Description : Shared widths and state encoding for the polar decoder US read path.
// Revision    : 1.0
// ============================================================================
package pdec_pkg;

    localparam int PDEC_NUM_PATH = 8;
    localparam int PDEC_PTR_W    = 3;
    localparam int PDEC_STAGE_W  = 4;
    localparam int PDEC_IDX_W    = 3;

    typedef enum logic [0:0] {
        RDC_IDLE = 1'b0,
        RDC_SEND = 1'b1
    } rdc_state_e;

endpackage
`default_nettype wire

// File: rtl/pdec_us_seg_sel.sv
`default_nettype none
// ============================================================================
// Module      : pdec_us_seg_sel
// Description : Picks one path's US vector and extracts the stage segment,
//               zero-extended to the largest segment width.
// Revision    : 1.0
// ============================================================================
module pdec_us_seg_sel
    import pdec_pkg::*;
#(
    parameter int NUM_US  = 256,
    parameter int SEG_MAX = NUM_US / 2
) (
    input  logic [NUM_US*PDEC_NUM_PATH-1:0] us_data,
    input  logic [PDEC_PTR_W-1:0]           path_ptr,
    input  logic [PDEC_STAGE_W-1:0]         stage,
    output logic [SEG_MAX-1:0]              seg
);

    localparam int NUM_STAGE = $clog2(NUM_US);

    logic [NUM_US-1:0]  w_path_arr [PDEC_NUM_PATH];
    logic [NUM_US-1:0]  w_path;
    logic [SEG_MAX-1:0] w_cand [NUM_STAGE];
    logic               w_unused_bit0;

    for (genvar p = 0; p < PDEC_NUM_PATH; p++) begin : g_path
        assign w_path_arr[p] = us_data[p*NUM_US +: NUM_US];
    end

    assign w_path = w_path_arr[path_ptr];

    // Bit 0 belongs to no stage segment.
    assign w_unused_bit0 = w_path[0];

    for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
        assign w_cand[k] = SEG_MAX'(w_path[(2**k) +: (2**k)]);
    end

    always_comb begin
        seg = '0;
        for (int k = 0; k < NUM_STAGE; k++) begin
            if (stage == PDEC_STAGE_W'(k)) begin
                seg = w_cand[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pdec_us_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pdec_us_rd_ctrl
// Description : Snapshots per-lane US stage segments and streams them to the
//               g-function PE array in valid/ready beats.
// Revision    : 1.0
// ============================================================================
module pdec_us_rd_ctrl
    import pdec_pkg::*;
#(
    parameter int NUM_US   = 256,
    parameter int NUM_PATH = PDEC_NUM_PATH,
    parameter int BEAT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ctrl2rdc_rd_st,
    input  logic [PDEC_STAGE_W-1:0]      ctrl2rdc_stage,
    input  logic [PDEC_PTR_W*NUM_PATH-1:0] ctrl2rdc_path_ptr,
    input  logic [NUM_US*NUM_PATH-1:0]   uus2rdc_us_data,
    output logic                         rdc2pe_vld,
    input  logic                         rdc2pe_rdy,
    output logic [BEAT_W*NUM_PATH-1:0]   rdc2pe_us_beat,
    output logic                         rdc2pe_last,
    output logic [PDEC_IDX_W-1:0]        rdc2pe_beat_idx,
    output logic                         rdc2ctrl_rd_done,
    output logic                         rdc2ctrl_rd_err,
    output logic                         pdec_clk_en7
);

    localparam int SEG_MAX   = NUM_US / 2;
    localparam int NUM_STAGE = $clog2(NUM_US);
    localparam int LOG2_BEAT = $clog2(BEAT_W);
    localparam int NUM_WORD  = SEG_MAX / BEAT_W;

    rdc_state_e              r_state, w_state_nxt;
    logic [SEG_MAX-1:0]      w_seg [NUM_PATH];
    logic [SEG_MAX-1:0]      r_seg [NUM_PATH];
    logic [BEAT_W-1:0]       w_word [NUM_PATH][NUM_WORD];
    logic [PDEC_STAGE_W-1:0] r_stage;
    logic [PDEC_IDX_W-1:0]   r_beat_cnt;
    logic [PDEC_IDX_W-1:0]   w_last_idx;
    logic                    r_done, r_err;
    logic                    w_busy, w_stage_ok, w_start, w_bad, w_fire, w_fire_last;

    assign w_busy      = (r_state == RDC_SEND);
    assign w_stage_ok  = (ctrl2rdc_stage <= PDEC_STAGE_W'(NUM_STAGE - 1));
    assign w_start     = !w_busy && ctrl2rdc_rd_st && w_stage_ok;
    assign w_bad       = !w_busy && ctrl2rdc_rd_st && !w_stage_ok;
    assign w_fire      = w_busy && rdc2pe_rdy;
    assign w_fire_last = w_fire && (r_beat_cnt == w_last_idx);

    // Segments no wider than one beat need a single beat.
    always_comb begin
        w_last_idx = '0;
        if (int'(r_stage) > LOG2_BEAT) begin
            w_last_idx = PDEC_IDX_W'((1 << (int'(r_stage) - LOG2_BEAT)) - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RDC_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        rdc2pe_vld      = 1'b0;
        rdc2pe_last     = 1'b0;
        case (r_state)
            RDC_IDLE: begin
                if (w_start) begin
                    w_state_nxt = RDC_SEND;
                end
            end
            RDC_SEND: begin
                rdc2pe_vld  = 1'b1;
                rdc2pe_last = (r_beat_cnt == w_last_idx);
                if (w_fire_last) begin
                    w_state_nxt = RDC_IDLE;
                end
            end
            default: w_state_nxt = RDC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PATH; i++) begin
                r_seg[i] <= '0;
            end
            r_stage    <= '0;
            r_beat_cnt <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= w_fire_last || w_bad;
            r_err  <= w_bad;
            if (w_start) begin
                for (int i = 0; i < NUM_PATH; i++) begin
                    r_seg[i] <= w_seg[i];
                end
                r_stage    <= ctrl2rdc_stage;
                r_beat_cnt <= '0;
            end else if (w_fire) begin
                r_beat_cnt <= w_fire_last ? '0 : r_beat_cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_PATH; i++) begin : g_lane
        pdec_us_seg_sel #(
            .NUM_US  (NUM_US),
            .SEG_MAX (SEG_MAX)
        ) u_seg_sel (
            .us_data  (uus2rdc_us_data),
            .path_ptr (ctrl2rdc_path_ptr[i*PDEC_PTR_W +: PDEC_PTR_W]),
            .stage    (ctrl2rdc_stage),
            .seg      (w_seg[i])
        );

        for (genvar w = 0; w < NUM_WORD; w++) begin : g_word
            assign w_word[i][w] = r_seg[i][w*BEAT_W +: BEAT_W];
        end

        assign rdc2pe_us_beat[i*BEAT_W +: BEAT_W] = w_busy ? w_word[i][r_beat_cnt] : '0;
    end

    assign rdc2pe_beat_idx  = r_beat_cnt;
    assign rdc2ctrl_rd_done = r_done;
    assign rdc2ctrl_rd_err  = r_err;
    assign pdec_clk_en7     = ctrl2rdc_rd_st || w_busy;

endmodule
`default_nettype wire

// File: tb/tb_pdec_us_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pdec_us_rd_ctrl
// Description : Self-checking bench for pdec_us_rd_ctrl against a segment model.
// Revision    : 1.0
// ============================================================================
module tb_pdec_us_rd_ctrl;

    localparam int NUM_US   = 256;
    localparam int NUM_PATH = 8;
    localparam int BEAT_W   = 16;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        rd_st;
    logic [3:0]                  stage;
    logic [3*NUM_PATH-1:0]       ptr;
    logic [NUM_US*NUM_PATH-1:0]  us;
    logic                        rdy;
    logic                        vld, last, done, err, clk_en;
    logic [BEAT_W*NUM_PATH-1:0]  beat;
    logic [2:0]                  idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pdec_us_rd_ctrl #(
        .NUM_US   (NUM_US),
        .NUM_PATH (NUM_PATH),
        .BEAT_W   (BEAT_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .ctrl2rdc_rd_st    (rd_st),
        .ctrl2rdc_stage    (stage),
        .ctrl2rdc_path_ptr (ptr),
        .uus2rdc_us_data   (us),
        .rdc2pe_vld        (vld),
        .rdc2pe_rdy        (rdy),
        .rdc2pe_us_beat    (beat),
        .rdc2pe_last       (last),
        .rdc2pe_beat_idx   (idx),
        .rdc2ctrl_rd_done  (done),
        .rdc2ctrl_rd_err   (err),
        .pdec_clk_en7      (clk_en)
    );

    // Stage-s segment of path p is bits [2^(s+1)-1 : 2^s]; beat k is its k-th 16-bit word.
    function automatic logic [BEAT_W-1:0] exp_beat(input logic [NUM_US*NUM_PATH-1:0] flat,
                                                   input logic [2:0] p, input int s, input int k);
        logic [NUM_US-1:0] path, mask, seg;
        path = flat[int'(p)*NUM_US +: NUM_US];
        mask = (256'd1 << (1 << s)) - 256'd1;
        seg  = (path >> (1 << s)) & mask;
        return seg[k*BEAT_W +: BEAT_W];
    endfunction

    function automatic int n_beats(input int s);
        return ((1 << s) <= BEAT_W) ? 1 : (1 << s) / BEAT_W;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_us();
        for (int w = 0; w < NUM_US*NUM_PATH/32; w++) begin
            us[w*32 +: 32] = $urandom;
        end
    endtask

    // mode 0: rdy always 1; 1: random rdy; 2: rdy pattern 1,0,0,1 repeating
    task automatic run_read(input int s, input logic [3*NUM_PATH-1:0] p, input int mode,
                            input bit rewrite, input bit tail, output int done_cyc);
        logic [NUM_US*NUM_PATH-1:0] snap;
        logic [BEAT_W*NUM_PATH-1:0] expv;
        int n, k, cyc;
        bit fin, r;
        n = n_beats(s);
        stage = 4'(s);
        ptr   = p;
        rd_st = 1'b1;
        snap  = us;
        #1;
        checks++;
        if (clk_en !== 1'b1) begin
            errors++;
            $display("FAIL clk_en_start: got %b expected 1", clk_en);
        end
        step();
        rd_st = 1'b0;
        k = 0; cyc = 0; fin = 0; done_cyc = -1;
        while (!fin && cyc < 200) begin
            if (k < n) begin
                for (int i = 0; i < NUM_PATH; i++) begin
                    expv[i*BEAT_W +: BEAT_W] = exp_beat(snap, p[3*i +: 3], s, k);
                end
                checks++;
                if (vld !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL vld_during_send: s=%0d k=%0d got vld=%b done=%b expected vld=1 done=0",
                             s, k, vld, done);
                end
                checks++;
                if (beat !== expv) begin
                    errors++;
                    $display("FAIL beat_data: s=%0d k=%0d got %h expected %h", s, k, beat, expv);
                end
                checks++;
                if (idx !== k[2:0] || last !== (k == n - 1)) begin
                    errors++;
                    $display("FAIL idx_last: s=%0d got idx=%0d last=%b expected idx=%0d last=%b",
                             s, idx, last, k, (k == n - 1));
                end
                case (mode)
                    0:       r = 1'b1;
                    1:       r = 1'($urandom_range(0, 1));
                    default: r = (cyc % 4 == 0) || (cyc % 4 == 3);
                endcase
                rdy = r;
                if (rewrite && cyc == 1) rand_us();
                step();
                if (r) k++;
            end else begin
                checks++;
                if (vld !== 1'b0 || done !== 1'b1 || err !== 1'b0) begin
                    errors++;
                    $display("FAIL done_pulse: s=%0d got vld=%b done=%b err=%b expected 0 1 0",
                             s, vld, done, err);
                end
                fin = 1;
                done_cyc = cyc;
            end
            cyc++;
        end
        rdy = 1'b0;
        if (!fin) begin
            errors++;
            $display("FAIL read_timeout: s=%0d got %0d beats expected %0d", s, k, n);
        end
        if (tail) begin
            step();
            checks++;
            if (done !== 1'b0 || vld !== 1'b0) begin
                errors++;
                $display("FAIL done_one_cycle: got done=%b vld=%b expected 0 0", done, vld);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if ({vld, last, done, err, clk_en} !== 5'b0 || beat !== '0 || idx !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got vld=%b last=%b done=%b err=%b en=%b idx=%0d beat=%h expected all 0",
                     vld, last, done, err, clk_en, idx, beat);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_stage0();
        us = '0;
        us[2*NUM_US + 1] = 1'b1;
        ptr   = 24'd2;
        stage = 4'd0;
        rd_st = 1'b1;
        rdy   = 1'b1;
        step();
        rd_st = 1'b0;
        checks++;
        if (vld !== 1'b1 || beat[15:0] !== 16'h0001 || last !== 1'b1 || idx !== 3'd0) begin
            errors++;
            $display("FAIL stage0_beat: got vld=%b lane0=%h last=%b idx=%0d expected 1 0001 1 0",
                     vld, beat[15:0], last, idx);
        end
        step();
        checks++;
        if (done !== 1'b1 || vld !== 1'b0) begin
            errors++;
            $display("FAIL stage0_done: got done=%b vld=%b expected 1 0", done, vld);
        end
        rdy = 1'b0;
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL stage0_done_width: got %b expected 0", done);
        end
    endtask

    task automatic test_full_stage();
        logic [3*NUM_PATH-1:0] p;
        int dc;
        rand_us();
        for (int i = 0; i < NUM_PATH; i++) begin
            p[3*i +: 3] = 3'(i);
            for (int w = 0; w < 8; w++) begin
                us[i*NUM_US + 128 + w*16 +: 16] = {4'(i), 4'hA, 8'(w * 17 + 3)};
            end
        end
        run_read(7, p, 0, 1'b0, 1'b1, dc);
        checks++;
        if (dc !== 8) begin
            errors++;
            $display("FAIL full_stage_latency: got %0d expected 8", dc);
        end
    endtask

    task automatic test_stall();
        int dc;
        rand_us();
        run_read(5, 24'($urandom), 2, 1'b0, 1'b1, dc);
        checks++;
        if (dc !== 4) begin
            errors++;
            $display("FAIL stall_cycles: got %0d expected 4", dc);
        end
    endtask

    task automatic test_snapshot();
        int dc;
        rand_us();
        run_read(6, 24'($urandom), 0, 1'b1, 1'b1, dc);
    endtask

    task automatic test_illegal();
        for (int t = 0; t < 2; t++) begin
            stage = (t == 0) ? 4'd8 : 4'd15;
            rd_st = 1'b1;
            rdy   = 1'b1;
            step();
            rd_st = 1'b0;
            checks++;
            if (vld !== 1'b0 || err !== 1'b1 || done !== 1'b1) begin
                errors++;
                $display("FAIL illegal_stage: s=%0d got vld=%b err=%b done=%b expected 0 1 1",
                         stage, vld, err, done);
            end
            step();
            checks++;
            if (vld !== 1'b0 || err !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL illegal_after: got vld=%b err=%b done=%b expected 0 0 0", vld, err, done);
            end
        end
        rdy = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [3*NUM_PATH-1:0] p;
        int dc;
        rand_us();
        p = 24'($urandom);
        stage = 4'd7;
        ptr   = p;
        rd_st = 1'b1;
        rdy   = 1'b1;
        step();
        rd_st = 1'b0;
        repeat (3) step();
        checks++;
        if (vld !== 1'b1 || idx !== 3'd3) begin
            errors++;
            $display("FAIL reset_mid_pre: got vld=%b idx=%0d expected 1 3", vld, idx);
        end
        rst = 1'b1;
        rdy = 1'b0;
        step();
        rst = 1'b0;
        checks++;
        if (vld !== 1'b0 || done !== 1'b0 || idx !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid: got vld=%b done=%b idx=%0d expected 0 0 0", vld, done, idx);
        end
        step();
        checks++;
        if (done !== 1'b0 || vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_done: got done=%b vld=%b expected 0 0", done, vld);
        end
        run_read(7, p, 0, 1'b0, 1'b1, dc);
    endtask

    task automatic test_back_to_back();
        int dc;
        rand_us();
        run_read(5, 24'($urandom), 0, 1'b0, 1'b0, dc);
        rand_us();
        run_read(3, 24'($urandom), 1, 1'b0, 1'b0, dc);
        run_read(7, 24'($urandom), 1, 1'b0, 1'b1, dc);
    endtask

    task automatic test_random();
        int dc;
        for (int it = 0; it < 20; it++) begin
            rand_us();
            run_read(int'($urandom_range(0, 7)), 24'($urandom), 1, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), dc);
        end
        step();
    endtask

    initial begin
        rst   = 1'b1;
        rd_st = 1'b0;
        stage = '0;
        ptr   = '0;
        us    = '0;
        rdy   = 1'b0;
        test_reset();
        test_stage0();
        test_full_stage();
        test_stall();
        test_snapshot();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
